// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - Multi-cycle unsigned ALU: single-cycle add/sub/nand/compare,
// iterative shift-add multiply and restoring divide/modulo behind start/busy/done.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] alu_status
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MULT = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_DIV  = 3'd4;
    localparam logic [2:0] OP_MOD  = 3'd5;
    localparam logic [2:0] OP_LT   = 3'd6;
    localparam logic [2:0] OP_LTE  = 3'd7;

    localparam logic [WIDTH-1:0] DIV0_STATUS = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH:0]   rem_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] stat_q;

    logic [WIDTH-1:0] single_d;
    logic [WIDTH-1:0] mul_sum_d;
    logic [WIDTH:0]   rem_sh_d;
    logic [WIDTH:0]   rem_trial_d;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quot_d;
    logic             q_bit_d;
    logic             last_d;

    // Single-cycle ops work directly on the inputs so the result lands on the start edge.
    always_comb begin
        single_d = '0;
        case (alu_op)
            OP_ADD:  single_d = op_b + op_a;
            OP_SUB:  single_d = op_b - op_a;
            OP_NAND: single_d = ~(op_b & op_a);
            OP_LT:   single_d = WIDTH'(op_b < op_a);
            OP_LTE:  single_d = WIDTH'(op_b <= op_a);
            default: single_d = '0;
        endcase
    end

    // Multiplier a_q shifts right (LSB first), multiplicand b_q shifts left.
    // In divide, b_q holds the dividend and shifts out MSB first while quotient bits shift in.
    always_comb begin
        mul_sum_d   = acc_q + (a_q[0] ? b_q : '0);
        rem_sh_d    = {rem_q[WIDTH-1:0], b_q[WIDTH-1]};
        rem_trial_d = rem_sh_d - {1'b0, a_q};
        q_bit_d     = ~rem_trial_d[WIDTH];
        rem_d       = q_bit_d ? rem_trial_d : rem_sh_d;
        quot_d      = {b_q[WIDTH-2:0], q_bit_d};
        last_d      = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            stat_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= alu_op;
                        a_q   <= op_a;
                        b_q   <= op_b;
                        acc_q <= '0;
                        rem_q <= '0;
                        cnt_q <= '0;
                        case (alu_op)
                            OP_MULT: begin
                                busy_q  <= 1'b1;
                                state_q <= S_MUL;
                            end
                            OP_DIV, OP_MOD: begin
                                if (op_a == '0) begin
                                    out_q   <= (alu_op == OP_DIV) ? '1 : op_b;
                                    stat_q  <= DIV0_STATUS;
                                    done_q  <= 1'b1;
                                    state_q <= S_DONE;
                                end else begin
                                    busy_q  <= 1'b1;
                                    state_q <= S_DIV;
                                end
                            end
                            default: begin
                                out_q   <= single_d;
                                stat_q  <= single_d;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    acc_q <= mul_sum_d;
                    a_q   <= a_q >> 1;
                    b_q   <= b_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_d) begin
                        out_q   <= mul_sum_d;
                        stat_q  <= mul_sum_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    b_q   <= quot_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_d) begin
                        out_q   <= (op_q == OP_MOD) ? rem_d[WIDTH-1:0] : quot_d;
                        stat_q  <= (op_q == OP_MOD) ? rem_d[WIDTH-1:0] : quot_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign alu_out    = out_q;
    assign alu_status = stat_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - Directed and randomized self-checking bench for seq_alu.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  alu_op;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        busy;
    logic        done;
    logic [15:0] alu_out;
    logic [15:0] alu_status;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alu_op     (alu_op),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .alu_out    (alu_out),
        .alu_status (alu_status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT in IDLE; returns #1 after an edge, DUT in IDLE.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_out,
                          input logic [15:0] exp_stat, input int exp_lat, input int poke);
        logic [15:0] prev_out;
        logic [15:0] prev_stat;
        int          lat;
        int          busy_n;
        bit          hold_ok;
        prev_out  = alu_out;
        prev_stat = alu_status;
        hold_ok   = 1'b1;
        busy_n    = 0;
        start  = 1'b1;
        alu_op = op;
        op_a   = a;
        op_b   = b;
        @(posedge clk); #1;
        start  = 1'b0;
        op_a   = 16'($urandom);
        op_b   = 16'($urandom);
        alu_op = 3'($urandom);
        lat = 1;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            if (alu_out !== prev_out || alu_status !== prev_stat) hold_ok = 1'b0;
            start = (lat == poke);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy_cycles"}, busy_n, (exp_lat == 17) ? 16 : 0);
        chk({tag, " busy_at_done"}, {31'b0, busy}, 0);
        chk({tag, " alu_out"}, {16'b0, alu_out}, {16'b0, exp_out});
        chk({tag, " alu_status"}, {16'b0, alu_status}, {16'b0, exp_stat});
        chk({tag, " hold"}, {31'b0, hold_ok}, 1);
        @(posedge clk); #1;
        chk({tag, " done_one_cycle"}, {31'b0, done}, 0);
    endtask

    task automatic model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] o, output logic [15:0] s, output int lat);
        logic [31:0] prod;
        prod = {16'b0, b} * {16'b0, a};
        lat  = 1;
        case (op)
            3'd0: o = b + a;
            3'd1: o = b - a;
            3'd2: begin o = prod[15:0]; lat = 17; end
            3'd3: o = ~(b & a);
            3'd4: if (a == 0) o = 16'hFFFF; else begin o = b / a; lat = 17; end
            3'd5: if (a == 0) o = b;        else begin o = b % a; lat = 17; end
            3'd6: o = (b < a) ? 16'd1 : 16'd0;
            default: o = (b <= a) ? 16'd1 : 16'd0;
        endcase
        s = ((op == 3'd4 || op == 3'd5) && a == 0) ? 16'h8000 : o;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [15:0] ra, rb, eo, es;
        int          elat;
        bit          saw_done;

        reset  = 1'b0;
        start  = 1'b0;
        alu_op = 3'd0;
        op_a   = 16'd0;
        op_b   = 16'd0;
        #2;
        chk("reset busy", {31'b0, busy}, 0);
        chk("reset done", {31'b0, done}, 0);
        chk("reset alu_out", {16'b0, alu_out}, 0);
        chk("reset alu_status", {16'b0, alu_status}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        run_op("add",       3'd0, 16'd3,     16'hFFFE, 16'h0001, 16'h0001, 1, 0);
        run_op("sub_eq",    3'd1, 16'd5,     16'd5,    16'h0000, 16'h0000, 1, 0);
        run_op("lt_true",   3'd6, 16'd7,     16'd2,    16'h0001, 16'h0001, 1, 0);
        run_op("sub_wrap",  3'd1, 16'd1,     16'd0,    16'hFFFF, 16'hFFFF, 1, 0);
        run_op("nand",      3'd3, 16'hF0F0,  16'hFF00, 16'h0FFF, 16'h0FFF, 1, 0);
        run_op("lte_eq",    3'd7, 16'd5,     16'd5,    16'h0001, 16'h0001, 1, 0);
        run_op("lt_eq",     3'd6, 16'd5,     16'd5,    16'h0000, 16'h0000, 1, 0);
        run_op("lte_false", 3'd7, 16'd4,     16'd5,    16'h0000, 16'h0000, 1, 0);
        run_op("mult",      3'd2, 16'h0123,  16'h0045, 16'h4E6F, 16'h4E6F, 17, 5);
        run_op("mult_max",  3'd2, 16'hFFFF,  16'hFFFF, 16'h0001, 16'h0001, 17, 0);
        run_op("div",       3'd4, 16'd7,     16'd100,  16'd14,   16'd14,   17, 9);
        run_op("mod",       3'd5, 16'd7,     16'd100,  16'd2,    16'd2,    17, 0);
        run_op("div_by1",   3'd4, 16'd1,     16'hFFFF, 16'hFFFF, 16'hFFFF, 17, 0);
        run_op("mod_big",   3'd5, 16'hFFFF,  16'hFFFE, 16'hFFFE, 16'hFFFE, 17, 0);
        run_op("div0",      3'd4, 16'd0,     16'd9,    16'hFFFF, 16'h8000, 1, 0);
        run_op("mod0",      3'd5, 16'd0,     16'd9,    16'd9,    16'h8000, 1, 0);

        // Abort a divide with reset partway through.
        start  = 1'b1;
        alu_op = 3'd4;
        op_a   = 16'd7;
        op_b   = 16'd100;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("abort busy_before", {31'b0, busy}, 1);
        reset = 1'b0;
        #1;
        chk("abort busy", {31'b0, busy}, 0);
        chk("abort done", {31'b0, done}, 0);
        chk("abort alu_out", {16'b0, alu_out}, 0);
        chk("abort alu_status", {16'b0, alu_status}, 0);
        @(negedge clk);
        reset = 1'b1;
        saw_done = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort no_done", {31'b0, saw_done}, 0);
        run_op("add_after", 3'd0, 16'd1, 16'd2, 16'd3, 16'd3, 1, 0);

        for (int i = 0; i < 20; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            rb  = 16'($urandom);
            model(rop, ra, rb, eo, es, elat);
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, eo, es, elat, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
